ifu_fetch: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core: the reader side of the instruction ROM.
- Owns the fetch PC and drives the 8-bit word address into the 256x32 instruction memory, whose read is combinational.
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect, flush and fetch-address faults, and keeps a fetch counter.

---
 rtl/ifu_fetch.sv | 97 +++++++++
 tb/tb_ifu_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, addresses the combinational instruction ROM
// and fills the IF/ID pipeline register, flagging out-of-range or misaligned fetches.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        flush_i,
  output logic [7:0]  im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
  output logic        fetch_err_d,
  output logic [31:0] fetch_count
);

  // Upper bound kept 33 bits wide so a ROM ending at the top of memory cannot wrap.
  localparam logic [32:0] ImLimit = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
  } ifid_t;

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] fcnt_q, fcnt_d;
  ifid_t       ifid_q, ifid_d;

  logic [31:0] offset;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic        below_base;
  logic        above_top;
  logic        fault;
  logic        unused_offset;

  assign offset        = fpc_q - IM_BASE;
  assign im_addr       = offset[9:2];
  assign unused_offset = ^{offset[31:10], offset[1:0]};
  assign pc_plus4      = fpc_q + 32'd4;

  assign misaligned = |fpc_q[1:0];
  assign below_base = fpc_q < IM_BASE;
  assign above_top  = {1'b0, fpc_q} >= ImLimit;
  assign fault      = misaligned | below_base | above_top;

  always_comb begin
    fpc_d  = fpc_q;
    fcnt_d = fcnt_q;
    ifid_d = ifid_q;
    if (flush_i) begin
      fpc_d  = redirect_pc_i;
      ifid_d = '0;
    end else if (!stall_i) begin
      // The word at the current PC is committed even on redirect (branch delay slot).
      ifid_d.instr = fault ? 32'h0 : im_dout;
      ifid_d.pc    = fpc_q;
      ifid_d.pc4   = pc_plus4;
      ifid_d.valid = 1'b1;
      ifid_d.err   = fault;
      fcnt_d       = fcnt_q + 32'd1;
      fpc_d        = redirect_i ? redirect_pc_i : pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q  <= RESET_PC;
      fcnt_q <= '0;
      ifid_q <= '0;
    end else begin
      fpc_q  <= fpc_d;
      fcnt_q <= fcnt_d;
      ifid_q <= ifid_d;
    end
  end

  assign pc_f        = fpc_q;
  assign instr_d     = ifid_q.instr;
  assign pc_d        = ifid_q.pc;
  assign pc4_d       = ifid_q.pc4;
  assign valid_d     = ifid_q.valid;
  assign fetch_err_d = ifid_q.err;
  assign fetch_count = fcnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed walk through the fetch scenarios, then random stall,
// redirect, flush and reset traffic checked every cycle against a behavioural model.
module tb_ifu_fetch;

  localparam logic [31:0] ImBase  = 32'h0000_3000;
  localparam logic [31:0] ResetPc = 32'h0000_3000;
  localparam int unsigned ImWords = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        flush_i;
  logic [7:0]  im_addr;
  logic [31:0] im_dout;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        valid_d;
  logic        fetch_err_d;
  logic [31:0] fetch_count;

  logic [31:0] rom [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign im_dout = rom[im_addr];

  ifu_fetch #(
    .RESET_PC(ResetPc),
    .IM_BASE (ImBase),
    .IM_WORDS(ImWords)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .flush_i      (flush_i),
    .im_addr      (im_addr),
    .im_dout      (im_dout),
    .pc_f         (pc_f),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc4_d        (pc4_d),
    .valid_d      (valid_d),
    .fetch_err_d  (fetch_err_d),
    .fetch_count  (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: the ROM is a word array starting at ImBase.
  function automatic bit in_rom(input logic [31:0] pc);
    longint p = longint'(pc);
    longint lo = longint'(ImBase);
    longint hi = lo + 4 * longint'(ImWords);
    return (pc[1:0] == 2'b00) && (p >= lo) && (p < hi);
  endfunction

  function automatic logic [7:0] word_index(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - ImBase;
    return off[9:2];
  endfunction

  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
  logic        m_valid, m_err;
  bit          m_live = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc    <= ResetPc;
      m_instr <= 32'h0;
      m_pcd   <= 32'h0;
      m_pc4   <= 32'h0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      m_cnt   <= 32'h0;
      m_live  <= 1;
    end else if (m_live) begin
      if (flush_i) begin
        m_pc    <= redirect_pc_i;
        m_instr <= 32'h0;
        m_pcd   <= 32'h0;
        m_pc4   <= 32'h0;
        m_valid <= 1'b0;
        m_err   <= 1'b0;
      end else if (!stall_i) begin
        m_instr <= in_rom(m_pc) ? rom[word_index(m_pc)] : 32'h0;
        m_pcd   <= m_pc;
        m_pc4   <= m_pc + 32'd4;
        m_valid <= 1'b1;
        m_err   <= !in_rom(m_pc);
        m_cnt   <= m_cnt + 32'd1;
        m_pc    <= redirect_i ? redirect_pc_i : m_pc + 32'd4;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("pc_f", pc_f, m_pc);
      chk("im_addr", {24'h0, im_addr}, {24'h0, word_index(m_pc)});
      chk("instr_d", instr_d, m_instr);
      chk("pc_d", pc_d, m_pcd);
      chk("pc4_d", pc4_d, m_pc4);
      chk("valid_d", {31'h0, valid_d}, {31'h0, m_valid});
      chk("fetch_err_d", {31'h0, fetch_err_d}, {31'h0, m_err});
      chk("fetch_count", fetch_count, m_cnt);
    end
    if (stall_i && redirect_i && !flush_i)
      $display("warning: redirect_i with stall_i at %0t (protocol)", $time);
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_target();
    int sel;
    logic [31:0] edges [4];
    edges[0] = ImBase - 32'd4;
    edges[1] = ImBase + 32'h3FC;
    edges[2] = ImBase + 32'h400;
    edges[3] = 32'hFFFF_FFFC;
    sel = $urandom_range(0, 9);
    if (sel < 7) return ImBase + 32'(4 * $urandom_range(0, 255));
    if (sel == 7) return ImBase + 32'($urandom_range(0, 1023));
    if (sel == 8) return $urandom;
    return edges[$urandom_range(0, 3)];
  endfunction

  initial begin
    for (int k = 0; k < 256; k++) rom[k] = 32'h1000_0000 + 32'(k);
    reset = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    flush_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("lit reset pc_f", pc_f, 32'h3000);
    chk("lit reset valid_d", {31'h0, valid_d}, 32'h0);
    chk("lit reset count", fetch_count, 32'h0);
    reset = 1'b0;

    step();
    chk("lit first instr", instr_d, 32'h1000_0000);
    chk("lit first valid", {31'h0, valid_d}, 32'h1);
    step();
    stall_i = 1'b1;
    repeat (3) step();
    chk("lit stall pc_f", pc_f, 32'h3008);
    chk("lit stall instr", instr_d, 32'h1000_0001);
    chk("lit stall count", fetch_count, 32'd2);
    stall_i = 1'b0;
    step();
    chk("lit release instr", instr_d, 32'h1000_0002);
    chk("lit release pc_f", pc_f, 32'h300C);
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h3040;
    step();
    chk("lit redirect pc_f", pc_f, 32'h3040);
    chk("lit delay slot", instr_d, 32'h1000_0004);
    redirect_i = 1'b0;
    step();
    chk("lit target instr", instr_d, 32'h1000_0010);

    flush_i = 1'b1;
    stall_i = 1'b1;
    redirect_pc_i = 32'h3180;
    step();
    chk("lit flush valid", {31'h0, valid_d}, 32'h0);
    chk("lit flush instr", instr_d, 32'h0);
    chk("lit flush pc_f", pc_f, 32'h3180);
    chk("lit flush count", fetch_count, 32'd6);
    flush_i = 1'b0;
    stall_i = 1'b0;

    redirect_i = 1'b1;
    redirect_pc_i = 32'h3002;
    step();
    chk("lit misalign im_addr", {24'h0, im_addr}, 32'h0);
    redirect_i = 1'b0;
    step();
    chk("lit misalign err", {31'h0, fetch_err_d}, 32'h1);
    chk("lit misalign instr", instr_d, 32'h0);
    chk("lit misalign pc_f", pc_f, 32'h3006);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h3400;
    step();
    chk("lit top im_addr", {24'h0, im_addr}, 32'h0);
    redirect_i = 1'b0;
    step();
    chk("lit top err", {31'h0, fetch_err_d}, 32'h1);
    chk("lit top valid", {31'h0, valid_d}, 32'h1);
    chk("lit top pc_f", pc_f, 32'h3404);
    chk("lit top count", fetch_count, 32'd10);

    stall_i = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("lit stall reset pc_f", pc_f, 32'h3000);
    chk("lit stall reset count", fetch_count, 32'h0);
    chk("lit stall reset valid", {31'h0, valid_d}, 32'h0);
    reset = 1'b0;
    stall_i = 1'b0;

    for (int k = 0; k < 256; k++) rom[k] = $urandom;
    for (int i = 0; i < 3000; i++) begin
      int r;
      step();
      r = $urandom_range(0, 99);
      reset = (r == 0);
      flush_i = (r >= 1 && r <= 3);
      stall_i = (r >= 4 && r <= 27) || (flush_i && $urandom_range(0, 1) == 1);
      redirect_i = (r >= 28 && r <= 39) || (flush_i && $urandom_range(0, 1) == 1);
      redirect_pc_i = pick_target();
    end
    reset = 1'b0;
    flush_i = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
